// File: rtl/depp_pkg.sv
// DEPP shared definitions.
// Used by the host initiator and the peripheral.
package depp_pkg;

  localparam int DEPP_W = 8;

  localparam logic CMD_ADDR  = 1'b1;
  localparam logic CMD_DATA  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE,
    ST_GAP
  } depp_state_e;

  typedef struct packed {
    logic              addr;
    logic              write;
    logic [DEPP_W-1:0] wdata;
  } depp_cmd_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer, resets to 0.
// Shared with the peripheral for its strobes.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Shift the async input through two flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/depp_host.sv
// DEPP host initiator: one command per
// address/data strobe cycle, one response.
module depp_host
  import depp_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk_8mhz,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_addr,
  input  logic              i_cmd_write,
  input  logic [DEPP_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DEPP_W-1:0] o_rsp_rdata,
  output logic              o_rsp_timeout,
  output logic              o_depp_astb_n,
  output logic              o_depp_dstb_n,
  output logic              o_depp_write_n,
  inout  wire  [DEPP_W-1:0] io_depp_data,
  input  logic              i_depp_wait
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES);

  depp_state_e       r_state, w_state;
  depp_cmd_t         r_cmd, w_cmd;
  logic [7:0]        r_cnt, w_cnt;
  logic [7:0]        w_cnt_inc;
  logic              r_astb_n, w_astb_n;
  logic              r_dstb_n, w_dstb_n;
  logic              r_write_n, w_write_n;
  logic              r_drive, w_drive;
  logic [DEPP_W-1:0] r_rdata, w_rdata;
  logic              r_timeout, w_timeout;
  logic              r_rsp_valid, w_rsp_valid;
  logic              r_ready, w_ready;
  logic              w_wait_s;

  sync2 u_sync_wait (
    .i_clk   (i_clk_8mhz),
    .i_rst_n (i_rst_n),
    .i_d     (i_depp_wait),
    .o_q     (w_wait_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_cmd       = r_cmd;
    w_cnt       = r_cnt;
    w_astb_n    = r_astb_n;
    w_dstb_n    = r_dstb_n;
    w_write_n   = r_write_n;
    w_drive     = r_drive;
    w_rdata     = r_rdata;
    w_timeout   = r_timeout;
    w_rsp_valid = 1'b0;
    w_cnt_inc   = r_cnt + 8'd1;
    unique case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid && r_ready) begin
          w_cmd.addr  = i_cmd_addr;
          w_cmd.write = i_cmd_write;
          w_cmd.wdata = i_cmd_wdata;
          w_write_n   = (i_cmd_write != CMD_WRITE);
          w_drive     = (i_cmd_write == CMD_WRITE);
          w_cnt       = 8'd0;
          w_rdata     = '0;
          w_timeout   = 1'b0;
          w_state     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_astb_n = (r_cmd.addr != CMD_ADDR);
          w_dstb_n = (r_cmd.addr == CMD_ADDR);
          w_cnt    = 8'd0;
          w_state  = ST_STROBE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_STROBE: begin
        if (w_wait_s) begin
          w_astb_n = 1'b1;
          w_dstb_n = 1'b1;
          if (r_cmd.write == CMD_READ)
            w_rdata = io_depp_data;
          w_cnt   = 8'd0;
          w_state = ST_RELEASE;
        end else if (w_cnt_inc == TO_LAST) begin
          w_astb_n  = 1'b1;
          w_dstb_n  = 1'b1;
          w_timeout = 1'b1;
          w_cnt     = 8'd0;
          w_state   = ST_RELEASE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (!w_wait_s) begin
          w_rsp_valid = 1'b1;
          w_state     = ST_DONE;
        end else if (w_cnt_inc == TO_LAST) begin
          w_timeout   = 1'b1;
          w_rdata     = '0;
          w_rsp_valid = 1'b1;
          w_state     = ST_DONE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_DONE: begin
        w_write_n = 1'b1;
        w_drive   = 1'b0;
        w_state   = ST_GAP;
      end
      ST_GAP: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_ready = (w_state == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_cnt       <= 8'd0;
      r_astb_n    <= 1'b1;
      r_dstb_n    <= 1'b1;
      r_write_n   <= 1'b1;
      r_drive     <= 1'b0;
      r_rdata     <= '0;
      r_timeout   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd       <= w_cmd;
      r_cnt       <= w_cnt;
      r_astb_n    <= w_astb_n;
      r_dstb_n    <= w_dstb_n;
      r_write_n   <= w_write_n;
      r_drive     <= w_drive;
      r_rdata     <= w_rdata;
      r_timeout   <= w_timeout;
      r_rsp_valid <= w_rsp_valid;
      r_ready     <= w_ready;
    end
  end

  assign o_cmd_ready    = r_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rdata;
  assign o_rsp_timeout  = r_timeout;
  assign o_depp_astb_n  = r_astb_n;
  assign o_depp_dstb_n  = r_dstb_n;
  assign o_depp_write_n = r_write_n;
  assign io_depp_data   = r_drive ? r_cmd.wdata
                                  : {DEPP_W{1'bz}};

endmodule

// File: tb/tb_depp_host.sv
// Bench for depp_host against a behavioural
// DEPP responder with address/data registers.
module tb_depp_host;

  localparam int SETUP = 2;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_addr = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       depp_wait = 1'b0;
  wire        cmd_ready;
  wire        rsp_valid;
  wire  [7:0] rsp_rdata;
  wire        rsp_timeout;
  wire        astb_n;
  wire        dstb_n;
  wire        write_n;
  wire  [7:0] depp_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mreg [2];

  logic       mute = 1'b0;
  logic [7:0] resp_addr = 8'h00;
  logic [7:0] resp_data = 8'h00;
  int         lo_cnt = 0;
  int         hi_cnt = 0;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h00;

  wire       strb_lo = !astb_n || !dstb_n;
  wire       resp_oe = write_n && strb_lo;
  wire [7:0] resp_val = !astb_n ? resp_addr
                                : resp_data;

  assign depp_data = resp_oe  ? resp_val :
                     probe_en ? probe_val :
                     8'hzz;

  always #5 clk = ~clk;

  depp_host #(
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk_8mhz     (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_write    (cmd_write),
    .i_cmd_wdata    (cmd_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_timeout  (rsp_timeout),
    .o_depp_astb_n  (astb_n),
    .o_depp_dstb_n  (dstb_n),
    .o_depp_write_n (write_n),
    .io_depp_data   (depp_data),
    .i_depp_wait    (depp_wait)
  );

  // Responder: wait up 2 clocks after strobe
  // low, down 2 clocks after strobes high.
  always @(posedge clk) begin
    if (strb_lo) begin
      hi_cnt <= 0;
      if (lo_cnt < 2) lo_cnt <= lo_cnt + 1;
      if (lo_cnt == 1 && !mute) begin
        depp_wait <= 1'b1;
        if (!write_n) begin
          if (!astb_n) resp_addr <= depp_data;
          else         resp_data <= depp_data;
        end
      end
    end else begin
      lo_cnt <= 0;
      if (hi_cnt < 2) hi_cnt <= hi_cnt + 1;
      if (hi_cnt == 1) depp_wait <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic check_hz(input string name,
                          input logic [7:0] v);
    probe_val = v;
    probe_en  = 1'b1;
    #1;
    check(name, depp_data, v);
    probe_en  = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cmd_ready; i++)
      @(negedge clk);
    check("ready_wait", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic a,
                         input logic w,
                         input logic [7:0] d,
                         input logic m,
                         output logic [7:0] rd,
                         output logic to);
    int t_strb, t_srise, t_wrise;
    int t_wfall, t_rsp, low_cnt;
    bit wrong, unstable;
    t_strb = -1; t_srise = -1; t_wrise = -1;
    t_wfall = -1; t_rsp = -1; low_cnt = 0;
    wrong = 0; unstable = 0;
    rd = 8'h00; to = 1'b0;
    mute = m;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (a ? !dstb_n : !astb_n) wrong = 1;
      if (a ? !astb_n : !dstb_n) begin
        low_cnt++;
        if (t_strb < 0) t_strb = n;
      end else if (t_strb >= 0 && t_srise < 0) begin
        t_srise = n;
      end
      if (depp_wait && t_wrise < 0) t_wrise = n;
      if (!depp_wait && t_wrise >= 0 && t_wfall < 0)
        t_wfall = n;
      if (w && t_wfall < 0 &&
          (write_n !== 1'b0 || depp_data !== d))
        unstable = 1;
      if (!w && write_n !== 1'b1) unstable = 1;
      if (rsp_valid) begin
        t_rsp = n;
        rd = rsp_rdata;
        to = rsp_timeout;
        break;
      end
      @(negedge clk);
    end
    check("rsp_seen", t_rsp >= 0, 1);
    check("setup_lat", t_strb, SETUP + 1);
    check("wrong_strobe", wrong, 0);
    check("bus_stable", unstable, 0);
    if (m) begin
      check("strobe_len", low_cnt, TO);
    end else begin
      check("wait_to_strobe", t_srise - t_wrise, 3);
      check("wait_to_rsp", t_rsp - t_wfall, 3);
    end
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
    @(negedge clk);
    check("ready_after_gap", cmd_ready, 1);
    check_hz("hz_after", w ? ~d : 8'hA5);
  endtask

  typedef struct {
    logic       a;
    logic       w;
    logic [7:0] d;
    logic       m;
    logic [7:0] exp_rd;
    logic       exp_to;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] rd;
    logic       to;
    logic       a, w;
    logic [7:0] d;
    int acc [$];
    int rsp [$];
    int seen;

    tbl[0] = '{1, 1, 8'h5A, 0, 8'h00, 0};
    tbl[1] = '{1, 0, 8'h00, 0, 8'h5A, 0};
    tbl[2] = '{0, 1, 8'hC3, 0, 8'h00, 0};
    tbl[3] = '{0, 0, 8'h00, 0, 8'hC3, 0};
    tbl[4] = '{1, 1, 8'h11, 0, 8'h00, 0};
    tbl[5] = '{0, 0, 8'h00, 0, 8'hC3, 0};
    tbl[6] = '{1, 0, 8'h00, 0, 8'h11, 0};
    tbl[7] = '{0, 0, 8'h00, 1, 8'h00, 1};
    tbl[8] = '{1, 1, 8'h77, 1, 8'h00, 1};
    tbl[9] = '{1, 0, 8'h00, 0, 8'h11, 0};
    mreg[0] = 8'h00;
    mreg[1] = 8'h00;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_astb", astb_n, 1);
    check("rst_dstb", dstb_n, 1);
    check("rst_write_n", write_n, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_timeout", rsp_timeout, 0);
    check_hz("rst_hz", 8'hA5);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].a, tbl[i].w, tbl[i].d,
              tbl[i].m, rd, to);
      check("tbl_rdata", rd, tbl[i].exp_rd);
      check("tbl_timeout", to, tbl[i].exp_to);
      if (tbl[i].w && !tbl[i].m) begin
        mreg[tbl[i].a] = tbl[i].d;
        check("resp_reg",
              tbl[i].a ? resp_addr : resp_data,
              tbl[i].d);
      end
    end

    // Reset one cycle after strobe falls.
    wait_ready();
    mute = 1'b0;
    d = mreg[0];
    cmd_valid = 1'b1;
    cmd_addr  = 1'b0;
    cmd_write = 1'b1;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && dstb_n; n++)
      @(negedge clk);
    check("mid_strobe_low", dstb_n, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_astb", astb_n, 1);
    check("mid_dstb", dstb_n, 1);
    check("mid_write_n", write_n, 1);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_ready", cmd_ready, 0);
    check_hz("mid_hz", ~d);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready_after", cmd_ready, 1);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("mid_no_rsp", seen, 0);

    // Back-to-back with valid held high.
    wait_ready();
    mute = 1'b0;
    cmd_addr  = 1'b0;
    cmd_write = 1'b1;
    cmd_wdata = 8'h3C;
    cmd_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready && cmd_valid) acc.push_back(n);
      if (rsp_valid) begin
        rsp.push_back(n);
        if (rsp.size() == 3) begin
          cmd_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    check("b2b_accepts", acc.size(), 3);
    check("b2b_rsps", rsp.size(), 3);
    if (acc.size() == 3 && rsp.size() == 3) begin
      for (int k = 0; k < 2; k++)
        check("b2b_gap", acc[k+1] - rsp[k], 2);
    end
    mreg[0] = 8'h3C;
    check("b2b_resp_reg", resp_data, 8'h3C);

    // Random traffic against the register model.
    for (int i = 0; i < 30; i++) begin
      a = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      run_cmd(a, w, d, 1'b0, rd, to);
      if (w) begin
        check("rnd_wr_rdata", rd, 8'h00);
        mreg[a] = d;
      end else begin
        check("rnd_rd_rdata", rd, mreg[a]);
      end
      check("rnd_timeout", to, 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
